uart_cmd_controller: RTL and testbench

Byte-level command sequencer that sits directly behind `UART_receiver` in the logic analyzer front end. It consumes received bytes, frames them into fixed-format command packets, and validates an XOR checksum. Valid packets become single-cycle configuration-register writes or capture-arm pulses for the analyzer core. It is the only path from the host serial link to analyzer configuration.

---
 rtl/uart_cmd_controller_if.sv | 22 ++
 rtl/uart_cmd_controller.sv | 206 ++++++++++++++++++++
 tb/tb_uart_cmd_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_controller_if.sv
// Byte-in / config-out bundle between UART_receiver, uart_cmd_controller and the analyzer core.
interface uart_cmd_controller_if;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        cfg_wr_en;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        arm;
  logic        cmd_err;
  logic [1:0]  err_code;
  logic        busy;

  modport master (
    output rx_data, rx_rdy,
    input  cfg_wr_en, cfg_addr, cfg_data, arm, cmd_err, err_code, busy
  );

  modport slave (
    input  rx_data, rx_rdy,
    output cfg_wr_en, cfg_addr, cfg_data, arm, cmd_err, err_code, busy
  );
endinterface

// File: rtl/uart_cmd_controller.sv
// Frames UART bytes into A5-synced, XOR-checked command packets driving config writes / arm pulses.
// Optional inter-byte timeout is built only when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_controller #(
  parameter int unsigned NUM_REGS       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic                   input_clk,
  input logic                   reset,
  uart_cmd_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA_HI,
    S_DATA_LO,
    S_CHK,
    S_EXEC
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_ARM    = 2'b01;
  localparam logic [1:0] ERR_CHK   = 2'b01;
  localparam logic [1:0] ERR_CMD   = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  if (NUM_REGS < 2 || NUM_REGS > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_cmd_controller: NUM_REGS must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  state_t      state, next_state;
  logic        rdy_q;
  logic        strobe;
  logic        pend;
  logic [7:0]  pend_byte;
  logic        byte_vld;
  logic [7:0]  byte_val;
  logic [7:0]  chk_sum;
  logic [1:0]  op_q;
  logic [2:0]  addr_q;
  logic [7:0]  data_hi_q;
  logic [7:0]  data_lo_q;
  logic        addr_ok;
  logic        wr_set;
  logic        arm_set;
  logic        err_set;
  logic [1:0]  err_val;
  logic        tmo_expired;

  assign strobe = bus.rx_rdy & ~rdy_q;

  // A byte caught during EXEC is replayed as the first IDLE byte.
  assign byte_vld = strobe | pend;
  assign byte_val = pend ? pend_byte : bus.rx_data;
  assign addr_ok  = ({1'b0, byte_val[2:0]} < 4'(NUM_REGS));

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_cnt;

  assign tmo_expired = (state != S_IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == S_IDLE || byte_vld || tmo_expired) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    wr_set     = 1'b0;
    arm_set    = 1'b0;
    err_set    = 1'b0;
    err_val    = '0;
    case (state)
      S_IDLE: begin
        if (byte_vld && byte_val == SYNC_BYTE) next_state = S_CMD;
      end
      S_CMD: begin
        if (byte_vld) begin
          if (byte_val[7:6] == OP_WRITE && addr_ok) begin
            next_state = S_DATA_HI;
          end else if (byte_val[7:6] == OP_ARM) begin
            next_state = S_CHK;
          end else begin
            next_state = S_IDLE;
            err_set    = 1'b1;
            err_val    = ERR_CMD;
          end
        end
      end
      S_DATA_HI: begin
        if (byte_vld) next_state = S_DATA_LO;
      end
      S_DATA_LO: begin
        if (byte_vld) next_state = S_CHK;
      end
      S_CHK: begin
        if (byte_vld) begin
          if (byte_val == chk_sum) begin
            next_state = S_EXEC;
            wr_set     = (op_q == OP_WRITE);
            arm_set    = (op_q == OP_ARM);
          end else begin
            next_state = S_IDLE;
            err_set    = 1'b1;
            err_val    = ERR_CHK;
          end
        end
      end
      S_EXEC: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
    // A strobe in the expiry cycle takes priority over the timeout.
    if (tmo_expired && !byte_vld) begin
      next_state = S_IDLE;
      err_set    = 1'b1;
      err_val    = ERR_TMO;
    end
  end

  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      rdy_q     <= 1'b0;
      pend      <= 1'b0;
      pend_byte <= '0;
      chk_sum   <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      data_hi_q <= '0;
      data_lo_q <= '0;
    end else begin
      rdy_q <= bus.rx_rdy;
      if (state == S_EXEC && strobe) begin
        pend      <= 1'b1;
        pend_byte <= bus.rx_data;
      end else if (state == S_IDLE) begin
        pend <= 1'b0;
      end
      if (byte_vld) begin
        case (state)
          S_IDLE: begin
            if (byte_val == SYNC_BYTE) chk_sum <= '0;
          end
          S_CMD: begin
            chk_sum <= chk_sum ^ byte_val;
            op_q    <= byte_val[7:6];
            addr_q  <= byte_val[2:0];
          end
          S_DATA_HI: begin
            chk_sum   <= chk_sum ^ byte_val;
            data_hi_q <= byte_val;
          end
          S_DATA_LO: begin
            chk_sum   <= chk_sum ^ byte_val;
            data_lo_q <= byte_val;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      bus.cfg_wr_en <= 1'b0;
      bus.cfg_addr  <= '0;
      bus.cfg_data  <= '0;
      bus.arm       <= 1'b0;
      bus.cmd_err   <= 1'b0;
      bus.err_code  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.cfg_wr_en <= wr_set;
      bus.arm       <= arm_set;
      bus.cmd_err   <= err_set;
      bus.busy      <= (next_state != S_IDLE);
      if (err_set) bus.err_code <= err_val;
      if (wr_set) begin
        bus.cfg_addr <= addr_q;
        bus.cfg_data <= {data_hi_q, data_lo_q};
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Directed bench for uart_cmd_controller: frame table plus hand-timed corner sequences.
module tb_uart_cmd_controller;

  logic clk;
  logic reset;
  int   total;
  int   passed;
  int   wr_cnt, arm_cnt, err_cnt, wr4_cnt, err4_cnt;

  uart_cmd_controller_if bus ();
  uart_cmd_controller_if bus4 ();

  uart_cmd_controller #(.NUM_REGS(8), .TIMEOUT_CYCLES(200)) dut (
    .input_clk (clk),
    .reset     (reset),
    .bus       (bus)
  );

  uart_cmd_controller #(.NUM_REGS(4), .TIMEOUT_CYCLES(200)) dut4 (
    .input_clk (clk),
    .reset     (reset),
    .bus       (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.cfg_wr_en)  wr_cnt++;
    if (bus.arm)        arm_cnt++;
    if (bus.cmd_err)    err_cnt++;
    if (bus4.cfg_wr_en) wr4_cnt++;
    if (bus4.cmd_err)   err4_cnt++;
  end

  typedef struct {
    logic [39:0] bytes;
    int          n;
    int          wr;
    int          arm;
    int          err;
    logic [1:0]  code;
    logic [2:0]  addr;
    logic [15:0] data;
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [7:0] b, input logic r);
    bus.rx_data  = b;
    bus.rx_rdy   = r;
    bus4.rx_data = b;
    bus4.rx_rdy  = r;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    drive(b, 1'b1);
    repeat (2) @(negedge clk);
    drive(b, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic fast_byte(input logic [7:0] b);
    @(negedge clk);
    drive(b, 1'b1);
    @(negedge clk);
    drive(b, 1'b0);
  endtask

  initial begin
    int w0, a0, e0, w40, e40;
    logic [39:0] bv;

    vec[0]  = '{40'h00_00000000, 1, 0, 0, 0, 2'b00, 3'd0, 16'h0000};
    vec[1]  = '{40'hFF_00000000, 1, 0, 0, 0, 2'b00, 3'd0, 16'h0000};
    vec[2]  = '{40'hA5_05_12_34_23, 5, 1, 0, 0, 2'b00, 3'd5, 16'h1234};
    vec[3]  = '{40'hA5_40_40_0000, 3, 0, 1, 0, 2'b00, 3'd5, 16'h1234};
    vec[4]  = '{40'hA5_05_12_34_24, 5, 0, 0, 1, 2'b01, 3'd5, 16'h1234};
    vec[5]  = '{40'hA5_03_00_FF_FC, 5, 1, 0, 0, 2'b01, 3'd3, 16'h00FF};
    vec[6]  = '{40'hA5_C0_000000, 2, 0, 0, 1, 2'b10, 3'd3, 16'h00FF};
    vec[7]  = '{40'hA5_40_40_0000, 3, 0, 1, 0, 2'b10, 3'd3, 16'h00FF};
    vec[8]  = '{40'hA5_02_A5_00_A7, 5, 1, 0, 0, 2'b10, 3'd2, 16'hA500};
    vec[9]  = '{40'hA5_07_FF_FF_07, 5, 1, 0, 0, 2'b10, 3'd7, 16'hFFFF};
    vec[10] = '{40'hA5_78_78_0000, 3, 0, 1, 0, 2'b10, 3'd7, 16'hFFFF};
    vec[11] = '{40'hA5_80_000000, 2, 0, 0, 1, 2'b10, 3'd7, 16'hFFFF};
    vec[12] = '{40'hA5_05_12_34_24, 5, 0, 0, 1, 2'b01, 3'd7, 16'hFFFF};
    vec[13] = '{40'hA5_A5_000000, 2, 0, 0, 1, 2'b10, 3'd7, 16'hFFFF};

    total = 0; passed = 0;
    wr_cnt = 0; arm_cnt = 0; err_cnt = 0; wr4_cnt = 0; err4_cnt = 0;
    reset = 1'b0;
    drive(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("rst wr_en",    {31'd0, bus.cfg_wr_en}, 32'd0);
    check("rst addr",     {29'd0, bus.cfg_addr},  32'd0);
    check("rst data",     {16'd0, bus.cfg_data},  32'd0);
    check("rst arm",      {31'd0, bus.arm},       32'd0);
    check("rst cmd_err",  {31'd0, bus.cmd_err},   32'd0);
    check("rst err_code", {30'd0, bus.err_code},  32'd0);
    check("rst busy",     {31'd0, bus.busy},      32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      w0 = wr_cnt; a0 = arm_cnt; e0 = err_cnt;
      bv = vec[i].bytes;
      for (int j = 0; j < vec[i].n; j++) send_byte(bv[39 - 8*j -: 8], 3);
      repeat (4) @(negedge clk);
      check($sformatf("v%0d wr pulses", i),  wr_cnt - w0,  vec[i].wr);
      check($sformatf("v%0d arm pulses", i), arm_cnt - a0, vec[i].arm);
      check($sformatf("v%0d err pulses", i), err_cnt - e0, vec[i].err);
      check($sformatf("v%0d err_code", i),   {30'd0, bus.err_code}, {30'd0, vec[i].code});
      check($sformatf("v%0d cfg_addr", i),   {29'd0, bus.cfg_addr}, {29'd0, vec[i].addr});
      check($sformatf("v%0d cfg_data", i),   {16'd0, bus.cfg_data}, {16'd0, vec[i].data});
      check($sformatf("v%0d busy", i),       {31'd0, bus.busy}, 32'd0);
    end

    // busy rise and write-strobe latency
    @(negedge clk); drive(8'hA5, 1'b1);
    @(negedge clk);
    check("busy after sync", {31'd0, bus.busy}, 32'd1);
    @(negedge clk); drive(8'hA5, 1'b0);
    repeat (2) @(negedge clk);
    send_byte(8'h01, 3); send_byte(8'hAB, 3); send_byte(8'hCD, 3);
    @(negedge clk); drive(8'h67, 1'b1);
    @(negedge clk);
    check("lat wr_en k+1", {31'd0, bus.cfg_wr_en}, 32'd1);
    check("lat addr k+1",  {29'd0, bus.cfg_addr},  32'd1);
    check("lat data k+1",  {16'd0, bus.cfg_data},  32'hABCD);
    check("lat busy exec", {31'd0, bus.busy},      32'd1);
    @(negedge clk);
    check("lat wr_en k+2", {31'd0, bus.cfg_wr_en}, 32'd0);
    check("lat busy k+2",  {31'd0, bus.busy},      32'd0);
    check("lat data hold", {16'd0, bus.cfg_data},  32'hABCD);
    drive(8'h67, 1'b0);
    repeat (3) @(negedge clk);

    // checksum error timing
    send_byte(8'hA5, 3); send_byte(8'h01, 3); send_byte(8'hAB, 3); send_byte(8'hCD, 3);
    @(negedge clk); drive(8'h68, 1'b1);
    @(negedge clk);
    check("chkerr pulse", {31'd0, bus.cmd_err},   32'd1);
    check("chkerr code",  {30'd0, bus.err_code},  32'd1);
    check("chkerr no wr", {31'd0, bus.cfg_wr_en}, 32'd0);
    check("chkerr busy",  {31'd0, bus.busy},      32'd0);
    @(negedge clk);
    check("chkerr width", {31'd0, bus.cmd_err},   32'd0);
    check("chkerr code held", {30'd0, bus.err_code}, 32'd1);
    drive(8'h68, 1'b0);
    repeat (3) @(negedge clk);

    // bad opcode error timing
    send_byte(8'hA5, 3);
    @(negedge clk); drive(8'hC0, 1'b1);
    @(negedge clk);
    check("operr pulse", {31'd0, bus.cmd_err},  32'd1);
    check("operr code",  {30'd0, bus.err_code}, 32'd2);
    check("operr busy",  {31'd0, bus.busy},     32'd0);
    drive(8'hC0, 1'b0);
    repeat (3) @(negedge clk);

    // back-to-back frames at minimum strobe spacing
    w0 = wr_cnt; a0 = arm_cnt; e0 = err_cnt;
    fast_byte(8'hA5); fast_byte(8'h40); fast_byte(8'h40);
    fast_byte(8'hA5); fast_byte(8'h03); fast_byte(8'h00); fast_byte(8'hFF); fast_byte(8'hFC);
    repeat (5) @(negedge clk);
    check("b2b arm", arm_cnt - a0, 1);
    check("b2b wr",  wr_cnt - w0,  1);
    check("b2b err", err_cnt - e0, 0);
    check("b2b addr", {29'd0, bus.cfg_addr}, 32'd3);
    check("b2b data", {16'd0, bus.cfg_data}, 32'h00FF);

    // NUM_REGS=4 address bound
    w0 = wr_cnt; w40 = wr4_cnt; e40 = err4_cnt;
    send_byte(8'hA5, 3); send_byte(8'h06, 3); send_byte(8'h00, 3); send_byte(8'h00, 3); send_byte(8'h06, 3);
    repeat (4) @(negedge clk);
    check("n4 addr6 err",  err4_cnt - e40, 1);
    check("n4 addr6 code", {30'd0, bus4.err_code}, 32'd2);
    check("n4 addr6 no wr", wr4_cnt - w40, 0);
    check("n8 addr6 wr",   wr_cnt - w0, 1);
    check("n8 addr6 addr", {29'd0, bus.cfg_addr}, 32'd6);
    w40 = wr4_cnt; e40 = err4_cnt;
    send_byte(8'hA5, 3); send_byte(8'h03, 3); send_byte(8'h00, 3); send_byte(8'h01, 3); send_byte(8'h02, 3);
    repeat (4) @(negedge clk);
    check("n4 addr3 wr",   wr4_cnt - w40, 1);
    check("n4 addr3 err",  err4_cnt - e40, 0);
    check("n4 addr3 data", {16'd0, bus4.cfg_data}, 32'h0001);

    // long but sub-timeout gaps between bytes
    w0 = wr_cnt; e0 = err_cnt;
    send_byte(8'hA5, 150); send_byte(8'h05, 150); send_byte(8'h12, 150); send_byte(8'h34, 150);
    send_byte(8'h23, 3);
    repeat (4) @(negedge clk);
    check("gap wr",   wr_cnt - w0,  1);
    check("gap err",  err_cnt - e0, 0);
    check("gap data", {16'd0, bus.cfg_data}, 32'h1234);

    // stalled frame
    w0 = wr_cnt; e0 = err_cnt;
    send_byte(8'hA5, 3); send_byte(8'h05, 150);
    check("stall busy early", {31'd0, bus.busy}, 32'd1);
    check("stall no early err", err_cnt - e0, 0);
    repeat (110) @(negedge clk);
`ifdef UART_CMD_TIMEOUT_EN
    check("tmo err",  err_cnt - e0, 1);
    check("tmo code", {30'd0, bus.err_code}, 32'd3);
    check("tmo busy", {31'd0, bus.busy}, 32'd0);
`else
    check("stall busy late", {31'd0, bus.busy}, 32'd1);
    check("stall no err", err_cnt - e0, 0);
    send_byte(8'hA5, 3); send_byte(8'h05, 3); send_byte(8'h12, 3); send_byte(8'h34, 3); send_byte(8'h23, 3);
    repeat (4) @(negedge clk);
    check("stall chk err",  err_cnt - e0, 1);
    check("stall chk code", {30'd0, bus.err_code}, 32'd1);
    check("stall no wr",    wr_cnt - w0, 0);
    check("stall busy end", {31'd0, bus.busy}, 32'd0);
`endif

    // reset mid-frame
    send_byte(8'hA5, 3); send_byte(8'h05, 3); send_byte(8'h12, 3);
    w0 = wr_cnt; a0 = arm_cnt; e0 = err_cnt;
    @(negedge clk);
    #2 reset = 1'b0;
    #5 reset = 1'b1;
    #1;
    check("mid rst addr",  {29'd0, bus.cfg_addr}, 32'd0);
    check("mid rst data",  {16'd0, bus.cfg_data}, 32'd0);
    check("mid rst code",  {30'd0, bus.err_code}, 32'd0);
    check("mid rst busy",  {31'd0, bus.busy},     32'd0);
    repeat (5) @(negedge clk);
    check("mid rst pulses", (wr_cnt - w0) + (arm_cnt - a0) + (err_cnt - e0), 0);
    send_byte(8'hA5, 3); send_byte(8'h04, 3); send_byte(8'hBE, 3); send_byte(8'hEF, 3); send_byte(8'h55, 3);
    repeat (4) @(negedge clk);
    check("post rst wr",   wr_cnt - w0, 1);
    check("post rst err",  err_cnt - e0, 0);
    check("post rst addr", {29'd0, bus.cfg_addr}, 32'd4);
    check("post rst data", {16'd0, bus.cfg_data}, 32'hBEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
